hilo_md_ctrl: RTL
=================

Name: hilo_md_ctrl

Overview:
- Sequencing controller for the HI/LO multiply/divide resource of the pipelined MIPS core.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and runs iterative 32-step shift-add multiply or restoring divide.
- Owns the HI/LO registers and stalls the pipeline while a new MD op or an MFHI/MFLO arrives and the unit is busy.
- Provides HI/LO read data selected by a HI/LO select, equivalent to the HI/LO writeback select.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op_valid  in  1  EX-stage MD/MT instruction present
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are ignored
- a  in  WIDTH  rs operand (dividend/multiplicand/MT source)
- b  in  WIDTH  rt operand (divisor/multiplier)
- rd_req  in  1  MFHI/MFLO in EX
- rd_hlsel  in  1  0 = LO, 1 = HI
- rd_data  out  WIDTH  combinational, hlsel ? HI : LO
- hi, lo  out  WIDTH  architectural HI/LO registers
- busy  out  1  state != IDLE
- stall  out  1  pipeline freeze request
- done  out  1  one-cycle pulse on the edge HI/LO are written by MD
- div_by_zero  out  1  registered; set when DIV/DIVU accepted with b == 0; cleared on next accepted MD op

Behaviour:
- Reset (async, rst_n = 0): state IDLE; hi, lo, counter, accumulators = 0; busy, done, div_by_zero = 0. Reset mid-operation aborts the op with no HI/LO write.
- States:
  - IDLE: on op_valid with MD op -> MUL or DIV; latch |a| and |b| (signed ops, magnitudes) or raw values (unsigned ops), latch result sign flags, clear counter.
  - MUL/DIV: one iteration per clock. When counter == WIDTH-1, go to FIX.
  - FIX: apply sign correction, write HI/LO, pulse done, go to IDLE.
- Latency: accept on edge k; HI/LO updated on edge k+WIDTH+1, which is 33 for WIDTH=32; busy is high for cycles k+1 .. k+WIDTH+1.
- MTHI/MTLO in IDLE: write a to HI/LO on the same edge, single cycle, no busy.
- stall = busy && ((op_valid && op <= 3'b101) || rd_req). While stalled, op_valid/op/a/b are ignored; the pipeline holds them.
- The unit is not restartable while busy. op_valid in the FIX cycle stalls; the op is accepted on the following IDLE cycle.
- MULT: product magnitude is negated in two's complement over 2*WIDTH bits if a and b signs differ. HI = [2W-1:W], LO = [W-1:0]. MULTU has no correction.
- DIV: LO = quotient, HI = remainder. Quotient is negated if signs differ; remainder takes the sign of the dividend. DIVU has no correction.
- Overflow, -2^31 / -1: LO = 0x80000000 (wraps), HI = 0.
- Divide by zero (either signedness): full latency, then HI = a, LO = all ones; no sign correction; div_by_zero = 1.
- rd_req and an MD/MT op both in IDLE in the same cycle: rd_data returns the old HI/LO value (read-before-write), no stall.
- rd_data is valid only when busy = 0; it is undefined-but-stable (current registers) while busy.

Test Plan:
- Reset mid-MULT: rst_n low at cycle 10 of a MULT 7*9 -> hi = lo = 0, busy = 0 immediately, no done pulse.
- MULT 0xFFFFFFFF(-1) * 5 -> edge k+33 gives hi = 0xFFFFFFFF, lo = 0xFFFFFFFB, single done pulse, busy high exactly 33 cycles; MULTU same operands -> hi = 0x00000004, lo = 0xFFFFFFFB.
- DIV -7 / 2 -> lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1); DIVU 100 / 7 -> lo = 14, hi = 2; DIV 0x80000000 / -1 -> lo = 0x80000000, hi = 0.
- DIVU 0x1234 / 0 -> div_by_zero = 1, hi = 0x1234, lo = 0xFFFFFFFF after full latency; next MULT clears the flag.
- MFHI (rd_req = 1, hlsel = 1) issued 3 cycles after DIV start -> stall high until the FIX edge; the first unstalled cycle returns the new HI.
- In IDLE, MTLO a = 0xDEADBEEF with rd_req hlsel = 0 in the same cycle -> rd_data = old lo; lo = 0xDEADBEEF on the next cycle; no stall, busy stays 0.

Source files
------------

// File: rtl/hilo_md_ctrl.sv
// HI/LO multiply/divide sequencer: 32-step shift-add multiply, restoring divide,
// MTHI/MTLO writes and pipeline stall generation for MFHI/MFLO and new MD ops.
module hilo_md_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_req,
  input  logic             rd_hlsel,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dbz_op_q, dbz_op_d;
  logic               dbz_flag_q, dbz_flag_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               md_op;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;

  // op[0] = 0 selects the signed variant, op[1] selects divide.
  assign md_op = op_valid && (op[2] == 1'b0);
  assign a_neg = ~op[0] & a[WIDTH-1];
  assign b_neg = ~op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign prod_raw  = {acc_hi_q, acc_lo_q};
  assign prod_fix  = neg_res_q ? -prod_raw : prod_raw;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    dbz_op_d   = dbz_op_q;
    dbz_flag_d = dbz_flag_q;
    done_d     = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      S_IDLE: begin
        if (md_op) begin
          // Multiply keeps the multiplier in acc_lo; divide keeps the dividend there.
          state_d    = op[1] ? S_DIV : S_MUL;
          cnt_d      = '0;
          acc_hi_d   = '0;
          acc_lo_d   = op[1] ? a_mag : b_mag;
          opnd_d     = op[1] ? b_mag : a_mag;
          is_div_d   = op[1];
          neg_res_d  = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          dbz_op_d   = op[1] && (b == '0);
          dbz_flag_d = op[1] && (b == '0);
        end else if (op_valid && op == 3'b100) begin
          hi_d = a;
        end else if (op_valid && op == 3'b101) begin
          lo_d = a;
        end
      end
      S_MUL: begin
        acc_hi_d = mul_sum[WIDTH:1];
        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end
      S_DIV: begin
        if (!div_diff[WIDTH]) begin
          acc_hi_d = div_diff[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_hi_d = div_shift[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          // With a zero divisor the remainder path holds |a|; restoring its sign yields a.
          lo_d = dbz_op_q ? '1 : (neg_res_q ? -acc_lo_q : acc_lo_q);
          hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dbz_op_q   <= 1'b0;
      dbz_flag_q <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      dbz_op_q   <= dbz_op_d;
      dbz_flag_q <= dbz_flag_d;
      done_q     <= done_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign stall       = busy && ((op_valid && op <= 3'b101) || rd_req);
  assign rd_data     = rd_hlsel ? hi_q : lo_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign done        = done_q;
  assign div_by_zero = dbz_flag_q;
  assign dbg_state   = state_q;

endmodule
